flash_read_sched: RTL

Command sequencer for the SPI flash read path. On a start pulse it drives chip select, issues READ (0x03) plus a 24-bit address through an external byte-level SPI shift engine, then clocks out rd_len data bytes. Each byte is forwarded to the UART transmitter with tx_busy back-pressure. It sits between the debounced key/host trigger and the SPI byte engine and uart_tx, and replaces ad-hoc sequencing inside the read controller.

---
 rtl/flash_read_sched_pkg.sv | 42 ++++
 rtl/flash_read_sched_cyc_timer.sv | 40 ++++
 rtl/flash_read_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_read_sched_pkg.sv
// Shared definitions for the SPI flash read sequencer:
// opcodes, FSM state encoding and the delay-timer width.
package flash_pkg;

    // SPI flash opcodes
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_WREN = 8'h06;

    // Width of the cs_n setup/hold delay counter
    localparam int unsigned TMR_W = 8;

    // Sequencer state encoding
    localparam logic [3:0] ENC_IDLE    = 4'd0;
    localparam logic [3:0] ENC_SETUP   = 4'd1;
    localparam logic [3:0] ENC_CMD     = 4'd2;
    localparam logic [3:0] ENC_A2      = 4'd3;
    localparam logic [3:0] ENC_A1      = 4'd4;
    localparam logic [3:0] ENC_A0      = 4'd5;
    localparam logic [3:0] ENC_DATA    = 4'd6;
    localparam logic [3:0] ENC_WAIT_TX = 4'd7;
    localparam logic [3:0] ENC_HOLD    = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE    = ENC_IDLE,
        ST_SETUP   = ENC_SETUP,
        ST_CMD     = ENC_CMD,
        ST_A2      = ENC_A2,
        ST_A1      = ENC_A1,
        ST_A0      = ENC_A0,
        ST_DATA    = ENC_DATA,
        ST_WAIT_TX = ENC_WAIT_TX,
        ST_HOLD    = ENC_HOLD
    } state_e;

    // True in the opcode/address byte phases
    function automatic logic is_hdr(state_e s);
        return (s == ST_CMD) || (s == ST_A2) ||
               (s == ST_A1)  || (s == ST_A0);
    endfunction

endpackage

// File: rtl/flash_read_sched_cyc_timer.sv
// cyc_timer: loadable down-counter used for the cs_n setup and hold delays.
// Ports: clk_i/rst_i clock and async reset, load_i/val_i load a cycle count,
// expire_o is high during the last counted cycle.
module cyc_timer
    import flash_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Loaded with N on the entry edge, so the count reads N..1 over
    // exactly N cycles; the cycle showing 1 is the last one.
    assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/flash_read_sched.sv
// flash_read_sched: sequences cs_n, READ opcode, 24-bit address and rd_len
// data bytes through a byte-level SPI engine, forwarding each byte to uart_tx.
// Ports: start/start_addr/rd_len/abort control, busy/done/aborted status,
// cs_n/spi_req/spi_wdata/spi_done/spi_rdata to the SPI engine,
// tx_busy/tx_flag/tx_data to uart_tx. All outputs are registered.
module flash_read_sched #(
    parameter logic [7:0]  CMD_READ     = 8'h03,
    parameter int unsigned CS_SETUP_CYC = 4,
    parameter int unsigned CS_HOLD_CYC  = 4,
    parameter int unsigned LEN_W        = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [23:0]      start_addr,
    input  logic [LEN_W-1:0] rd_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cs_n,
    output logic             spi_req,
    output logic [7:0]       spi_wdata,
    input  logic             spi_done,
    input  logic [7:0]       spi_rdata,
    input  logic             tx_busy,
    output logic             tx_flag,
    output logic [7:0]       tx_data
);

    import flash_pkg::*;

    state_e           state_q;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] rem_q;
    logic [7:0]       rx_q;
    logic             out_q;
    logic             req_pend_q;
    logic             abort_q;

    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             cs_n_q;
    logic             spi_req_q;
    logic [7:0]       spi_wdata_q;
    logic             tx_flag_q;
    logic [7:0]       tx_data_q;

    logic             accept;
    logic             abt;
    logic             go_setup;
    logic             go_hold;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_exp;

    always_comb begin
        // Only a byte we actually requested can complete
        accept   = spi_done && out_q;
        abt      = abort_q || abort;
        go_setup = (state_q == ST_IDLE) && start &&
                   (rd_len != '0);
        go_hold  = (is_hdr(state_q) && accept && abt) ||
                   ((state_q == ST_WAIT_TX) && !tx_busy &&
                    ((rem_q == LEN_W'(1)) || abt));
        tmr_load = go_setup || go_hold;
        tmr_val  = go_setup ? TMR_W'(CS_SETUP_CYC)
                            : TMR_W'(CS_HOLD_CYC);
    end

    cyc_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .load_i   (tmr_load),
        .val_i    (tmr_val),
        .expire_o (tmr_exp)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rx_q        <= '0;
            out_q       <= 1'b0;
            req_pend_q  <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            spi_req_q   <= 1'b0;
            spi_wdata_q <= '0;
            tx_flag_q   <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            spi_req_q <= 1'b0;
            tx_flag_q <= 1'b0;
            done_q    <= 1'b0;

            if (accept) begin
                out_q <= 1'b0;
            end else if (spi_req_q) begin
                out_q <= 1'b1;
            end

            if ((state_q != ST_IDLE) && abort) begin
                abort_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        aborted_q <= 1'b0;
                        if (go_setup) begin
                            addr_q  <= start_addr;
                            rem_q   <= rd_len;
                            cs_n_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                        end else begin
                            // Zero-length read: finish without
                            // touching the bus
                            done_q <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    if (tmr_exp) begin
                        spi_req_q   <= 1'b1;
                        spi_wdata_q <= CMD_READ;
                        state_q     <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (go_hold) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (accept) begin
                        spi_req_q   <= 1'b1;
                        spi_wdata_q <= addr_q[23:16];
                        state_q     <= ST_A2;
                    end
                end

                ST_A2: begin
                    if (go_hold) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (accept) begin
                        spi_req_q   <= 1'b1;
                        spi_wdata_q <= addr_q[15:8];
                        state_q     <= ST_A1;
                    end
                end

                ST_A1: begin
                    if (go_hold) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (accept) begin
                        spi_req_q   <= 1'b1;
                        spi_wdata_q <= addr_q[7:0];
                        state_q     <= ST_A0;
                    end
                end

                ST_A0: begin
                    if (go_hold) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (accept) begin
                        spi_req_q   <= 1'b1;
                        spi_wdata_q <= 8'h00;
                        state_q     <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    // Re-entry from WAIT_TX defers the request one
                    // cycle so it lands just after tx_flag
                    if (req_pend_q) begin
                        req_pend_q  <= 1'b0;
                        spi_req_q   <= 1'b1;
                        spi_wdata_q <= 8'h00;
                    end else if (accept) begin
                        rx_q    <= spi_rdata;
                        state_q <= ST_WAIT_TX;
                    end
                end

                ST_WAIT_TX: begin
                    // cs_n stays low while stalled; SCK is idle
                    // so the flash continues the stream later
                    if (!tx_busy) begin
                        tx_flag_q <= 1'b1;
                        tx_data_q <= rx_q;
                        rem_q     <= rem_q - LEN_W'(1);
                        if (go_hold) begin
                            cs_n_q  <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            req_pend_q <= 1'b1;
                            state_q    <= ST_DATA;
                        end
                    end
                end

                ST_HOLD: begin
                    if (tmr_exp) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        aborted_q <= abt;
                        abort_q   <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign cs_n      = cs_n_q;
    assign spi_req   = spi_req_q;
    assign spi_wdata = spi_wdata_q;
    assign tx_flag   = tx_flag_q;
    assign tx_data   = tx_data_q;

endmodule
